// File: rtl/wac_pkg.sv
// Shared definitions for the ADC-to-BRAM acquisition scheduler.
// Holds the FSM state encoding, the FIFO depth, the address/sample widths
// and a helper that splits a 12-bit sample into the two bytes stored in BRAM.
package wac_pkg;

  localparam int ADDR_W     = 12;
  localparam int SMP_W      = 12;
  localparam int BYTE_W     = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;  // wide enough to hold 0..FIFO_DEPTH

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // {high byte, low byte} as written to memory: high byte is zero-extended.
  function automatic logic [2*BYTE_W-1:0] smp_bytes(input logic [SMP_W-1:0] s);
    return {4'b0000, s[11:8], s[7:0]};
  endfunction

endpackage

// File: rtl/smp_fifo2.sv
// Two-entry sample FIFO (shift-register organisation, entry 0 is the head).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   push_i, din_i    : write strobe and sample; caller never pushes into a
//                      full FIFO unless it pops in the same cycle
//   pop_i            : removes the head
//   dout_o           : head entry
//   dout_nxt_o       : entry behind the head (becomes head after a pop)
//   full_o, empty_o  : occupancy flags
module smp_fifo2
  import wac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [SMP_W-1:0] din_i,
  output logic [SMP_W-1:0] dout_o,
  output logic [SMP_W-1:0] dout_nxt_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [SMP_W-1:0] ent0_q;
  logic [SMP_W-1:0] ent1_q;
  logic [CNT_W-1:0] cnt_q;

  // Storage and occupancy update for push, pop and simultaneous push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= 12'h000;
      ent1_q <= 12'h000;
      cnt_q  <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            ent0_q <= din_i;
            cnt_q  <= 2'd1;
          end else if (cnt_q == 2'd1) begin
            ent1_q <= din_i;
            cnt_q  <= 2'd2;
          end else begin
            cnt_q  <= cnt_q;
          end
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged except when popping an empty FIFO.
          if (cnt_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= din_i;
          end else begin
            ent0_q <= din_i;
            cnt_q  <= 2'd1;
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  assign dout_o     = ent0_q;
  assign dout_nxt_o = ent1_q;
  assign full_o     = (cnt_q == FIFO_DEPTH[CNT_W-1:0]);
  assign empty_o    = (cnt_q == 2'd0);

endmodule

// File: rtl/adc_bram_sched.sv
// ADC acquisition scheduler: buffers ADC samples in a 2-entry FIFO and writes
// each one to BRAM port B as two bytes (low at addr, high at addr+1), while
// sharing the same port with a command reader at lower priority.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, nSamples, baseAddr  : acquisition request (operands latched at start)
//   readyAdc, dataAdc          : ADC sample strobe and data
//   rdReq, rdAddr              : reader request (level) and address
//   rdGnt, rdValid, rdData     : read issued / read data returned one cycle later
//   bramAddr, bramDin, bramWe  : BRAM port B command
//   bramDout                   : BRAM port B read data (1-cycle latency)
//   busy, done, overrun        : status
module adc_bram_sched
  import wac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] nSamples,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic              readyAdc,
  input  logic [SMP_W-1:0]  dataAdc,
  input  logic              rdReq,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic              rdGnt,
  output logic              rdValid,
  output logic [BYTE_W-1:0] rdData,
  output logic [ADDR_W-1:0] bramAddr,
  output logic [BYTE_W-1:0] bramDin,
  output logic              bramWe,
  input  logic [BYTE_W-1:0] bramDout,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] smp_addr_q, smp_addr_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              we_q, we_d;
  logic              hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0] din_q, din_d;
  logic              gnt_q, gnt_d;
  logic              vld_q;

  logic              push_s, pop_s, drop_s, run_s;
  logic              full_s, empty_s;
  logic [SMP_W-1:0]  head_s, head_nxt_s;
  logic              nxt_valid_s;
  logic [SMP_W-1:0]  nxt_smp_s;
  logic [2*BYTE_W-1:0] head_bytes_s, nxt_bytes_s;

  smp_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_s),
    .pop_i      (pop_s),
    .din_i      (dataAdc),
    .dout_o     (head_s),
    .dout_nxt_o (head_nxt_s),
    .full_o     (full_s),
    .empty_o    (empty_s)
  );

  // Next-cycle port B command, FIFO control and FSM next state.
  // The port outputs are registered, so the command for the next cycle is
  // decided here from the FIFO state that will exist after this edge: a
  // sample pushed now is written as its low byte in the very next cycle.
  // The FIFO is non-empty exactly when a write byte is on the port, and the
  // head is popped at the end of the cycle that carries its high byte.
  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    smp_addr_d  = smp_addr_q;
    overrun_d   = overrun_q;
    we_d        = 1'b0;
    hi_d        = 1'b0;
    addr_d      = 12'h000;
    din_d       = 8'h00;
    gnt_d       = 1'b0;
    nxt_valid_s = 1'b0;
    nxt_smp_s   = 12'h000;

    run_s  = (state_q == ST_RUN);
    pop_s  = we_q & hi_q;
    push_s = run_s & readyAdc & (~full_s | pop_s);
    drop_s = run_s & readyAdc & full_s & ~pop_s;

    // Sample whose low byte would be written next, if any.
    if (we_q && hi_q) begin
      if (full_s) begin
        nxt_valid_s = 1'b1;
        nxt_smp_s   = head_nxt_s;
      end else if (push_s) begin
        nxt_valid_s = 1'b1;
        nxt_smp_s   = dataAdc;
      end else begin
        nxt_valid_s = 1'b0;
      end
    end else if (!we_q && push_s) begin
      nxt_valid_s = 1'b1;
      nxt_smp_s   = dataAdc;
    end else begin
      nxt_valid_s = 1'b0;
    end

    head_bytes_s = smp_bytes(head_s);
    nxt_bytes_s  = smp_bytes(nxt_smp_s);

    // Fixed priority: pending write byte first, then the reader.
    if (we_q && !hi_q) begin
      we_d   = 1'b1;
      hi_d   = 1'b1;
      addr_d = addr_q + 12'h001;
      din_d  = head_bytes_s[15:8];
    end else if (nxt_valid_s) begin
      we_d       = 1'b1;
      addr_d     = smp_addr_q;
      din_d      = nxt_bytes_s[7:0];
      smp_addr_d = smp_addr_q + 12'h002;
    end else if (rdReq) begin
      addr_d = rdAddr;
      gnt_d  = 1'b1;
    end else begin
      addr_d = 12'h000;
    end

    if (drop_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d        = nSamples;
          smp_addr_d = baseAddr;
          cnt_d      = 12'h000;
          overrun_d  = 1'b0;
          state_d    = (nSamples == 12'h000) ? ST_FIN : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (push_s) begin
          cnt_d = cnt_q + 12'h001;
          if ((cnt_q + 12'h001) == n_q) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (empty_s && !we_q) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
  end

  // State, operand, status and port B command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      n_q        <= 12'h000;
      cnt_q      <= 12'h000;
      smp_addr_q <= 12'h000;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      hi_q       <= 1'b0;
      addr_q     <= 12'h000;
      din_q      <= 8'h00;
      gnt_q      <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      smp_addr_q <= smp_addr_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      we_q       <= we_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      gnt_q      <= gnt_d;
      vld_q      <= gnt_q;
    end
  end

  assign bramWe   = we_q;
  assign bramAddr = addr_q;
  assign bramDin  = din_q;
  assign rdGnt    = gnt_q;
  assign rdValid  = vld_q;
  // BRAM data only appears in the cycle after the grant, so it is forwarded
  // directly and qualified by the registered valid.
  assign rdData   = vld_q ? bramDout : 8'h00;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_adc_bram_sched.sv
// Directed testbench for adc_bram_sched with a behavioural BRAM port B.
module tb_adc_bram_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [11:0] nSamples, baseAddr;
  logic        readyAdc;
  logic [11:0] dataAdc;
  logic        rdReq;
  logic [11:0] rdAddr;
  logic        rdGnt, rdValid;
  logic [7:0]  rdData;
  logic [11:0] bramAddr;
  logic [7:0]  bramDin;
  logic        bramWe;
  logic [7:0]  bramDout = 8'h00;
  logic        busy, done, overrun;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [7:0]  mem [0:4095];
  logic        preload = 1'b0;

  logic [11:0] wr_addr [$];
  logic [7:0]  wr_data [$];
  int          wr_cyc  [$];
  int          done_cnt = 0, conflict_cnt = 0, rd_err_cnt = 0;
  int          gnt_cnt = 0, gnt_busy_cnt = 0;
  logic        gnt_prev = 1'b0;
  logic [7:0]  exp_rd = 8'h00;

  adc_bram_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nSamples(nSamples), .baseAddr(baseAddr),
    .readyAdc(readyAdc), .dataAdc(dataAdc), .rdReq(rdReq), .rdAddr(rdAddr),
    .rdGnt(rdGnt), .rdValid(rdValid), .rdData(rdData),
    .bramAddr(bramAddr), .bramDin(bramDin), .bramWe(bramWe), .bramDout(bramDout),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Read-first synchronous BRAM model.
  always @(posedge clk) begin
    if (preload) mem[12'h010] <= 8'h5A;
    else if (bramWe) mem[bramAddr] <= bramDin;
    bramDout <= mem[bramAddr];
  end

  // Port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bramWe) begin
      wr_addr.push_back(bramAddr);
      wr_data.push_back(bramDin);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rdGnt && bramWe) conflict_cnt <= conflict_cnt + 1;
    if (rdGnt) gnt_cnt <= gnt_cnt + 1;
    if (rdGnt && busy) gnt_busy_cnt <= gnt_busy_cnt + 1;
    if (rdValid !== gnt_prev) rd_err_cnt <= rd_err_cnt + 1;
    else if (rdValid && (rdData !== exp_rd)) rd_err_cnt <= rd_err_cnt + 1;
    gnt_prev <= rdGnt;
    exp_rd   <= mem[bramAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] b, input logic [11:0] n);
    start = 1'b1; baseAddr = b; nSamples = n;
    tick(1);
    start = 1'b0;
  endtask

  task automatic ready(input logic [11:0] d, output int t);
    readyAdc = 1'b1; dataAdc = d; t = cyc;
    tick(1);
    readyAdc = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max);
    int k = 0;
    while (done_cnt == base && k < max) begin
      tick(1);
      k++;
    end
  endtask

  function automatic logic [31:0] get_w(input int i);
    if (i < wr_addr.size()) return {12'h000, wr_addr[i], wr_data[i]};
    else return 32'hFFFFFFFF;
  endfunction

  logic [31:0] exp_basic [4] = '{32'h000100BC, 32'h0001010A, 32'h00010223, 32'h00010301};
  logic [31:0] exp_wrap  [4] = '{32'h000FFEA5, 32'h000FFF05, 32'h000000F0, 32'h00000100};

  initial begin
    int t0, t1, wb, db, cb, eb, gb, gbb;
    rst_n = 1'b0; start = 1'b0; nSamples = 12'h000; baseAddr = 12'h000;
    readyAdc = 1'b0; dataAdc = 12'h000; rdReq = 1'b0; rdAddr = 12'h000;
    preload = 1'b1;
    tick(2);
    preload = 1'b0;
    check("rst_flags", {28'h0, busy, done, overrun, bramWe}, 32'h0);
    check("rst_rd", {30'h0, rdGnt, rdValid}, 32'h0);
    check("rst_bus", {4'h0, bramAddr, bramDin, rdData}, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Basic run
    wb = wr_addr.size(); db = done_cnt;
    do_start(12'h100, 12'd2);
    check("basic_busy", {31'h0, busy}, 32'h1);
    tick(3);
    ready(12'hABC, t0);
    tick(9);
    ready(12'h123, t1);
    wait_done(db, 40);
    tick(2);
    check("basic_nwr", wr_addr.size() - wb, 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("basic_wr%0d", i), get_w(wb + i), exp_basic[i]);
    check("basic_lat_lo", (wr_cyc.size() > wb) ? wr_cyc[wb] : -1, t0 + 1);
    check("basic_lat_hi", (wr_cyc.size() > wb + 1) ? wr_cyc[wb + 1] : -1, t0 + 2);
    check("basic_done", done_cnt - db, 32'd1);
    check("basic_ovr", {31'h0, overrun}, 32'h0);
    check("basic_idle", {31'h0, busy}, 32'h0);

    // Address wrap
    wb = wr_addr.size(); db = done_cnt;
    do_start(12'hFFE, 12'd2);
    ready(12'h5A5, t0);
    tick(3);
    ready(12'h0F0, t1);
    wait_done(db, 40);
    tick(2);
    for (int i = 0; i < 4; i++) check($sformatf("wrap_wr%0d", i), get_w(wb + i), exp_wrap[i]);

    // Overrun: four back-to-back samples, fourth dropped
    wb = wr_addr.size(); db = done_cnt;
    do_start(12'h300, 12'd8);
    ready(12'h111, t0);
    ready(12'h222, t0);
    ready(12'h333, t0);
    ready(12'h444, t0);
    tick(10);
    check("ovr_nwr3", wr_addr.size() - wb, 32'd6);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    check("ovr_nodone", done_cnt - db, 32'd0);
    check("ovr_busy", {31'h0, busy}, 32'h1);
    ready(12'h555, t0); tick(4);
    ready(12'h666, t0); tick(4);
    ready(12'h777, t0); tick(4);
    ready(12'h888, t0); tick(4);
    ready(12'h999, t0);
    wait_done(db, 40);
    tick(2);
    check("ovr_nwr8", wr_addr.size() - wb, 32'd16);
    check("ovr_done", done_cnt - db, 32'd1);
    check("ovr_sticky", {31'h0, overrun}, 32'h1);
    check("ovr_wr4", get_w(wb + 4), 32'h00030433);
    check("ovr_wr6", get_w(wb + 6), 32'h00030655);

    // Contention with a reader holding rdReq
    wb = wr_addr.size(); db = done_cnt; cb = conflict_cnt; eb = rd_err_cnt;
    gb = gnt_cnt; gbb = gnt_busy_cnt;
    rdAddr = 12'h010; rdReq = 1'b1;
    tick(4);
    do_start(12'h200, 12'd3);
    ready(12'h0DE, t0);
    ready(12'h0AD, t0);
    tick(5);
    ready(12'h0BE, t0);
    wait_done(db, 40);
    rdReq = 1'b0;
    tick(3);
    check("cont_conflict", conflict_cnt - cb, 32'd0);
    check("cont_rddata", rd_err_cnt - eb, 32'd0);
    check("cont_idle_gnt", {31'h0, (gnt_cnt - gb) > (gnt_busy_cnt - gbb)}, 32'h1);
    check("cont_busy_gnt", {31'h0, (gnt_busy_cnt - gbb) > 0}, 32'h1);
    check("cont_nwr", wr_addr.size() - wb, 32'd6);
    check("cont_mem", {24'h0, mem[12'h200]}, 32'h000000DE);

    // Zero samples
    wb = wr_addr.size();
    do_start(12'h500, 12'd0);
    check("zero_done", {30'h0, done, busy}, 32'h3);
    check("zero_ovr", {31'h0, overrun}, 32'h0);
    tick(1);
    check("zero_after", {30'h0, done, busy}, 32'h0);
    tick(3);
    check("zero_nwr", wr_addr.size() - wb, 32'd0);

    // Reset in the middle of an acquisition
    wb = wr_addr.size(); db = done_cnt;
    do_start(12'h400, 12'd2);
    rdAddr = 12'h010; rdReq = 1'b1;
    ready(12'h777, t0);
    check("mid_lowwr", {31'h0, bramWe}, 32'h1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_flags", {26'h0, busy, done, overrun, bramWe, rdGnt, rdValid}, 32'h0);
    check("mid_bus", {4'h0, bramAddr, bramDin, rdData}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    rdReq = 1'b0;
    tick(1);
    ready(12'h321, t0);
    tick(3);
    ready(12'h654, t0);
    tick(10);
    check("mid_nwr", wr_addr.size() - wb, 32'd1);
    check("mid_nodone", done_cnt - db, 32'd0);
    check("mid_idle", {31'h0, busy}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_bram_sched.md
ADC_BRAM_SCHED -- requirements
Module: adc_bram_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic rising-edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins an acquisition.
REQ-004 SHALL have port nSamples, input, 12 bits: number of samples to store; sampled at start.
REQ-005 SHALL have port baseAddr, input, 12 bits: first BRAM byte address; sampled at start.
REQ-006 SHALL have port readyAdc, input, 1 bit: one-cycle strobe, dataAdc valid.
REQ-007 SHALL have port dataAdc, input, 12 bits: ADC sample.
REQ-008 SHALL have port rdReq, input, 1 bit: level request from the command reader.
REQ-009 SHALL have port rdAddr, input, 12 bits: read address; held stable while rdReq is high.
REQ-010 SHALL have port rdGnt, output, 1 bit: read issued to BRAM this cycle.
REQ-011 SHALL have port rdValid, output, 1 bit: rdData valid.
REQ-012 SHALL have port rdData, output, 8 bits: read byte.
REQ-013 SHALL have ports bramAddr (12 bits), bramDin (8 bits) and bramWe (1 bit), outputs, driving BRAM port B.
REQ-014 SHALL have port bramDout, input, 8 bits: BRAM port B read data, 1-cycle synchronous latency.
REQ-015 SHALL have ports busy, done and overrun, outputs, 1 bit each: status.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FLUSH and FIN.
REQ-017 SHALL go IDLE->RUN on start, latching nSamples and baseAddr into internal registers, clearing the sample counter and clearing overrun.
REQ-018 SHALL, on start with nSamples=0, go IDLE->FIN; done SHALL pulse the next cycle with no writes.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL, in RUN, push dataAdc into a 2-entry sample FIFO on every readyAdc; readyAdc outside RUN SHALL be ignored.
REQ-021 SHALL, when readyAdc arrives with the FIFO full and no pop in the same cycle, drop the sample and set overrun, which stays set until the next start.
REQ-022 SHALL, when push and pop occur together on a full FIFO, accept the push with no overrun.
REQ-023 SHALL write each sample as two bytes: low byte {dataAdc[7:0]} at addr, then high byte {4'b0000, dataAdc[11:8]} at addr+1, on consecutive cycles, popping after the high byte.
REQ-024 SHALL compute addr as baseAddr + 2*k for sample index k, modulo 4096 (wraps at 12 bits).
REQ-025 SHALL give write latency as follows: readyAdc at cycle t with an empty FIFO gives the low-byte bramWe at t+1 and the high-byte bramWe at t+2.
REQ-026 SHALL, once nSamples samples have been accepted, go RUN->FLUSH and ignore further readyAdc.
REQ-027 SHALL go FLUSH->FIN when the FIFO is empty and the last high byte has been written.
REQ-028 SHALL, in FIN, pulse done for exactly one cycle, then return to IDLE.
REQ-029 SHALL hold busy high in RUN, FLUSH and FIN and low in IDLE.
REQ-030 SHALL arbitrate port B with fixed priority, pending write over read.
REQ-031 SHALL, in a cycle with no write byte issued and rdReq high, drive bramAddr=rdAddr and bramWe=0, and assert rdGnt.
REQ-032 SHALL drive rdValid high and rdData=bramDout exactly one cycle after each rdGnt.
REQ-033 SHALL serve reads in any FSM state, including IDLE.
REQ-034 SHALL hold bramWe at 0 whenever no write byte is issued.
REQ-035 SHALL cap the sample counter at nSamples, with no wrap.

Reset
REQ-036 SHALL, on rst_n low, immediately force the FSM to IDLE, empty the FIFO, zero the counters, and drive busy=0, done=0, overrun=0, rdGnt=0, rdValid=0, rdData=0, bramWe=0, bramAddr=0 and bramDin=0.
REQ-037 SHALL, when reset occurs mid-acquisition, abandon the acquisition with no further writes and no done pulse.

Structure
REQ-038 SHALL take state encodings, the FIFO depth (2) and the address width (12) from the shared wac package.
REQ-039 SHALL implement the 2-entry sample FIFO as sub-module smp_fifo2 with push, pop, full, empty and data ports.

Verification
REQ-040 SHALL verify basic run: baseAddr=0x100, nSamples=2, readyAdc every 10 cycles with 0xABC and 0x123 -> writes (0x100,0xBC), (0x101,0x0A), (0x102,0x23), (0x103,0x01), then a single done pulse and overrun=0.
REQ-041 SHALL verify address wrap: baseAddr=0xFFE, nSamples=2 -> writes to 0xFFE, 0xFFF, 0x000, 0x001.
REQ-042 SHALL verify overrun: readyAdc on 4 consecutive cycles, nSamples=8 -> 3 samples accepted, overrun=1, no done until 5 further samples arrive.
REQ-043 SHALL verify contention: rdReq held with rdAddr=0x010 during an acquisition -> rdGnt is low on every bramWe cycle, and each rdGnt is followed one cycle later by rdValid carrying memory[0x010].
REQ-044 SHALL verify zero samples: start with nSamples=0 -> done one cycle later and bramWe never asserted.
REQ-045 SHALL verify reset mid-operation: rst_n low after the first low-byte write -> all outputs 0 at once, and no writes or done after release.
